// File: rtl/lemmings_world_if.sv
// rtl/lemmings_world_if.sv - lemming FSM <-> world handshake bundle
// master = lemming FSM side, slave = world side.
interface lemmings_world_if;
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic digging;
  logic bump_left;
  logic bump_right;
  logic ground;
  logic dig;

  modport master (
    output walk_left, walk_right, aaah, digging,
    input  bump_left, bump_right, ground, dig
  );

  modport slave (
    input  walk_left, walk_right, aaah, digging,
    output bump_left, bump_right, ground, dig
  );
endinterface

// File: rtl/lemmings_world.sv
// rtl/lemmings_world.sv - destructible-terrain environment closing the loop around a lemming FSM
// Optional host terrain write port enabled by LEMMINGS_WORLD_CFG_EN.
module lemmings_world #(
  parameter int WIDTH        = 16,
  parameter int LAYERS       = 8,
  parameter int START_X      = 4,
  parameter int FALL_DIV     = 4,
  parameter int DIG_CYCLES   = 3,
  parameter int SPLAT_CYCLES = 20
) (
  input  logic                      clk,
  input  logic                      areset,
  lemmings_world_if.slave           lem,
  input  logic                      dig_req,
  input  logic                      cfg_we,
  input  logic [$clog2(LAYERS)-1:0] cfg_row,
  input  logic [$clog2(WIDTH)-1:0]  cfg_col,
  input  logic                      cfg_solid,
  output logic [$clog2(WIDTH)-1:0]  pos_x,
  output logic [$clog2(LAYERS)-1:0] pos_y,
  output logic                      splat
);

  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(LAYERS);
  localparam int DVW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam int DGW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
  localparam logic [XW-1:0]  X_MAX    = XW'(WIDTH - 1);
  localparam logic [YW-1:0]  Y_BED    = YW'(LAYERS - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(FALL_DIV - 1);
  localparam logic [DGW-1:0] DIG_LAST = DGW'(DIG_CYCLES - 1);

  logic [XW-1:0]    x, x_n;
  logic [YW-1:0]    y, y_n;
  logic [WIDTH-1:0] solid [LAYERS];
  logic [5:0]       fall_cnt, fall_n;
  logic [DVW-1:0]   div_cnt, div_n;
  logic [DGW-1:0]   dig_cnt, dig_n;
  logic             dig_pend, dig_pend_n;
  logic             splat_r, splat_n;
  logic             dig_clr;
  logic             on_ground;

  assign on_ground = solid[y][x];

  always_comb begin
    x_n     = x;
    y_n     = y;
    fall_n  = fall_cnt;
    div_n   = div_cnt;
    dig_n   = dig_cnt;
    splat_n = splat_r;
    dig_clr = 1'b0;
    if (!splat_r) begin
      if (on_ground && (lem.walk_left ^ lem.walk_right)) begin
        if (lem.walk_left && x != '0)
          x_n = x - 1'b1;
        if (lem.walk_right && x != X_MAX)
          x_n = x + 1'b1;
      end

      if (!lem.aaah) begin
        fall_n = '0;
        div_n  = '0;
      end else if (!on_ground) begin
        if (fall_cnt != 6'd63)
          fall_n = fall_cnt + 6'd1;
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (y != Y_BED)
            y_n = y + 1'b1;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end else begin
        // Landing: the accumulated fall length decides survival.
        if (fall_cnt >= 6'(SPLAT_CYCLES))
          splat_n = 1'b1;
        fall_n = '0;
        div_n  = '0;
      end

      if (!lem.digging) begin
        dig_n = '0;
      end else if (on_ground) begin
        if (dig_cnt == DIG_LAST) begin
          dig_n   = '0;
          dig_clr = (y != Y_BED);
        end else begin
          dig_n = dig_cnt + 1'b1;
        end
      end
    end
  end

  // Host request beats the lemming's acknowledge in the same cycle.
  assign dig_pend_n = dig_req ? 1'b1 : ((lem.digging || lem.aaah) ? 1'b0 : dig_pend);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      x        <= XW'(START_X);
      y        <= '0;
      fall_cnt <= '0;
      div_cnt  <= '0;
      dig_cnt  <= '0;
      dig_pend <= 1'b0;
      splat_r  <= 1'b0;
      for (int r = 0; r < LAYERS; r++)
        solid[r] <= '1;
    end else begin
      x        <= x_n;
      y        <= y_n;
      fall_cnt <= fall_n;
      div_cnt  <= div_n;
      dig_cnt  <= dig_n;
      dig_pend <= dig_pend_n;
      splat_r  <= splat_n;
      if (dig_clr)
        solid[y][x] <= 1'b0;
`ifdef LEMMINGS_WORLD_CFG_EN
      // Placed after the dig clear so a host write to the same tile wins.
      if (cfg_we && cfg_row < Y_BED)
        solid[cfg_row][cfg_col] <= cfg_solid;
`endif
    end
  end

`ifndef LEMMINGS_WORLD_CFG_EN
  logic unused_cfg;
  assign unused_cfg = &{1'b0, cfg_we, cfg_row, cfg_col, cfg_solid};
`endif

  assign lem.bump_left  = (x == '0);
  assign lem.bump_right = (x == X_MAX);
  assign lem.ground     = on_ground;
  assign lem.dig        = dig_pend;
  assign pos_x          = x;
  assign pos_y          = y;
  assign splat          = splat_r;

endmodule

// File: tb/tb_lemmings_world.sv
// tb/tb_lemmings_world.sv - directed self-checking bench for lemmings_world
// Deep-fall and host-write priority scenarios run only with LEMMINGS_WORLD_CFG_EN.
module tb_lemmings_world;
  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       dig_req = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_row = '0;
  logic [3:0] cfg_col = '0;
  logic       cfg_solid = 1'b0;
  logic [3:0] pos_x;
  logic [2:0] pos_y;
  logic       splat;
  int         errors = 0;
  int         checks = 0;

  lemmings_world_if lif ();

  lemmings_world dut (
    .clk       (clk),
    .areset    (areset),
    .lem       (lif),
    .dig_req   (dig_req),
    .cfg_we    (cfg_we),
    .cfg_row   (cfg_row),
    .cfg_col   (cfg_col),
    .cfg_solid (cfg_solid),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .splat     (splat)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    lif.walk_left = 0; lif.walk_right = 0; lif.aaah = 0; lif.digging = 0;
    areset = 1'b1;
    tick(2);
    checks++; if (pos_x !== 4'd4) begin errors++; $display("FAIL reset_pos_x: got %0d want 4", pos_x); end
    checks++; if (pos_y !== 3'd0) begin errors++; $display("FAIL reset_pos_y: got %0d want 0", pos_y); end
    checks++; if ({lif.bump_left, lif.bump_right, lif.ground, lif.dig, splat} !== 5'b00100) begin
      errors++; $display("FAIL reset_flags: got %b want 00100", {lif.bump_left, lif.bump_right, lif.ground, lif.dig, splat}); end
    areset = 1'b0;
    tick(1);
    checks++; if (pos_x !== 4'd4) begin errors++; $display("FAIL reset_idle_hold: got %0d want 4", pos_x); end
  endtask

  task automatic test_walk;
    lif.walk_right = 1;
    tick(11);
    checks++; if (pos_x !== 4'd15 || lif.bump_right !== 1'b1) begin
      errors++; $display("FAIL walk_right_wall: got x=%0d bump=%b want x=15 bump=1", pos_x, lif.bump_right); end
    tick(1);
    checks++; if (pos_x !== 4'd15) begin errors++; $display("FAIL walk_right_past_wall: got %0d want 15", pos_x); end
    lif.walk_left = 1;
    tick(1);
    checks++; if (pos_x !== 4'd15) begin errors++; $display("FAIL walk_both: got %0d want 15", pos_x); end
    lif.walk_right = 0;
    tick(15);
    checks++; if (pos_x !== 4'd0 || lif.bump_left !== 1'b1 || lif.bump_right !== 1'b0) begin
      errors++; $display("FAIL walk_left_wall: got x=%0d bl=%b br=%b want x=0 bl=1 br=0", pos_x, lif.bump_left, lif.bump_right); end
    tick(1);
    checks++; if (pos_x !== 4'd0) begin errors++; $display("FAIL walk_left_past_wall: got %0d want 0", pos_x); end
    lif.walk_left = 0; lif.walk_right = 1;
    tick(4);
    lif.walk_right = 0;
    checks++; if (pos_x !== 4'd4 || lif.bump_left !== 1'b0) begin
      errors++; $display("FAIL walk_back_to_4: got x=%0d bl=%b want x=4 bl=0", pos_x, lif.bump_left); end
  endtask

  task automatic test_dig_handshake;
    dig_req = 1;
    tick(1);
    dig_req = 0;
    checks++; if (lif.dig !== 1'b1) begin errors++; $display("FAIL dig_set: got %b want 1", lif.dig); end
    tick(2);
    checks++; if (lif.dig !== 1'b1) begin errors++; $display("FAIL dig_hold: got %b want 1", lif.dig); end
    lif.digging = 1;
    tick(1);
    checks++; if (lif.dig !== 1'b0) begin errors++; $display("FAIL dig_ack_clear: got %b want 0", lif.dig); end
    tick(1);
    checks++; if (lif.ground !== 1'b1) begin errors++; $display("FAIL dig_two_cycles_ground: got %b want 1", lif.ground); end
    tick(1);
    checks++; if (lif.ground !== 1'b0) begin errors++; $display("FAIL dig_three_cycles_ground: got %b want 0", lif.ground); end
    // Request and acknowledge together: the request must survive.
    dig_req = 1;
    tick(1);
    dig_req = 0;
    checks++; if (lif.dig !== 1'b1) begin errors++; $display("FAIL dig_set_wins: got %b want 1", lif.dig); end
    tick(1);
    lif.digging = 0;
    checks++; if (lif.dig !== 1'b0) begin errors++; $display("FAIL dig_clear_after: got %b want 0", lif.dig); end
    lif.walk_right = 1;
    tick(1);
    lif.walk_right = 0;
    checks++; if (pos_x !== 4'd4) begin errors++; $display("FAIL walk_no_ground: got %0d want 4", pos_x); end
  endtask

  task automatic test_short_fall;
    lif.aaah = 1;
    tick(3);
    checks++; if (pos_y !== 3'd0 || lif.ground !== 1'b0) begin
      errors++; $display("FAIL fall_three_cycles: got y=%0d g=%b want y=0 g=0", pos_y, lif.ground); end
    tick(1);
    checks++; if (pos_y !== 3'd1 || lif.ground !== 1'b1) begin
      errors++; $display("FAIL fall_four_cycles: got y=%0d g=%b want y=1 g=1", pos_y, lif.ground); end
    tick(1);
    lif.aaah = 0;
    checks++; if (splat !== 1'b0 || pos_y !== 3'd1) begin
      errors++; $display("FAIL short_landing: got splat=%b y=%0d want splat=0 y=1", splat, pos_y); end
  endtask

  task automatic test_bedrock;
    for (int r = 1; r < 7; r++) begin
      lif.digging = 1;
      tick(3);
      lif.digging = 0;
      lif.aaah = 1;
      tick(4);
      checks++; if (pos_y !== 3'(r + 1)) begin errors++; $display("FAIL descend_row_%0d: got %0d want %0d", r, pos_y, r + 1); end
      tick(1);
      lif.aaah = 0;
    end
    lif.digging = 1;
    tick(10);
    lif.digging = 0;
    checks++; if (lif.ground !== 1'b1 || pos_y !== 3'd7) begin
      errors++; $display("FAIL bedrock_dig: got g=%b y=%0d want g=1 y=7", lif.ground, pos_y); end
    checks++; if (splat !== 1'b0) begin errors++; $display("FAIL bedrock_no_splat: got %b want 0", splat); end
  endtask

  task automatic test_reset_mid_fall;
    areset = 1; #2; areset = 0;
    lif.digging = 1;
    tick(3);
    lif.digging = 0;
    lif.aaah = 1;
    tick(2);
    checks++; if (lif.ground !== 1'b0) begin errors++; $display("FAIL pre_reset_falling: got %b want 0", lif.ground); end
    #2 areset = 1;
    #1;
    checks++; if (pos_x !== 4'd4 || pos_y !== 3'd0 || lif.ground !== 1'b1 || splat !== 1'b0 || lif.dig !== 1'b0) begin
      errors++; $display("FAIL reset_mid_fall: got x=%0d y=%0d g=%b s=%b d=%b want 4 0 1 0 0", pos_x, pos_y, lif.ground, splat, lif.dig); end
    lif.aaah = 0;
    tick(1);
    areset = 0;
  endtask

  task automatic test_cfg_write;
    logic exp_g;
`ifdef LEMMINGS_WORLD_CFG_EN
    exp_g = 1'b0;
`else
    exp_g = 1'b1;
`endif
    cfg_we = 1; cfg_row = 3'd0; cfg_col = 4'd4; cfg_solid = 0;
    tick(1);
    cfg_we = 0;
    checks++; if (lif.ground !== exp_g) begin errors++; $display("FAIL cfg_clear: got %b want %b", lif.ground, exp_g); end
    cfg_we = 1; cfg_solid = 1;
    tick(1);
    cfg_we = 0;
    checks++; if (lif.ground !== 1'b1) begin errors++; $display("FAIL cfg_restore: got %b want 1", lif.ground); end
  endtask

`ifdef LEMMINGS_WORLD_CFG_EN
  task automatic test_cfg_priority;
    lif.digging = 1;
    tick(2);
    cfg_we = 1; cfg_row = 3'd0; cfg_col = 4'd4; cfg_solid = 1;
    tick(1);
    cfg_we = 0; lif.digging = 0;
    checks++; if (lif.ground !== 1'b1) begin errors++; $display("FAIL cfg_beats_dig: got %b want 1", lif.ground); end
  endtask

  task automatic test_deep_fall;
    lif.walk_right = 1;
    tick(4);
    lif.walk_right = 0;
    checks++; if (pos_x !== 4'd8) begin errors++; $display("FAIL deep_start_x: got %0d want 8", pos_x); end
    for (int r = 0; r < 7; r++) begin
      cfg_we = 1; cfg_row = 3'(r); cfg_col = 4'd8; cfg_solid = 0;
      tick(1);
    end
    cfg_we = 0;
    lif.aaah = 1;
    tick(27);
    checks++; if (pos_y !== 3'd6) begin errors++; $display("FAIL deep_27: got %0d want 6", pos_y); end
    tick(1);
    checks++; if (pos_y !== 3'd7 || lif.ground !== 1'b1 || splat !== 1'b0) begin
      errors++; $display("FAIL deep_28: got y=%0d g=%b s=%b want 7 1 0", pos_y, lif.ground, splat); end
    tick(1);
    checks++; if (splat !== 1'b1) begin errors++; $display("FAIL deep_splat: got %b want 1", splat); end
    lif.aaah = 0; lif.walk_left = 1;
    tick(2);
    lif.walk_left = 0;
    checks++; if (pos_x !== 4'd8 || pos_y !== 3'd7 || splat !== 1'b1) begin
      errors++; $display("FAIL deep_frozen: got x=%0d y=%0d s=%b want 8 7 1", pos_x, pos_y, splat); end
  endtask
`endif

  initial begin
    test_reset();
    test_walk();
    test_dig_handshake();
    test_short_fall();
    test_bedrock();
    test_reset_mid_fall();
    test_cfg_write();
`ifdef LEMMINGS_WORLD_CFG_EN
    test_cfg_priority();
    test_deep_fall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
